// File: rtl/cmd_issue_master.sv
// cmd_issue_master: issues one SD host command over the register-bank port
// (argument, command word, status poll, response read-back, status clear).
module cmd_issue_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int ACK_TIMEOUT = 16,
    parameter int POLL_MAX    = 255,
    parameter int POLL_GAP    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           cmd_arg,
    input  logic [15:0]           cmd_word,
    input  logic [15:0]           xfer_mode,
    input  logic                  long_resp,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    output logic [127:0]          response,
    output logic                  reg_req,
    output logic                  reg_rw,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ack
);
    localparam int ACW = $clog2(ACK_TIMEOUT + 1);
    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);
    localparam logic [ACW-1:0] ACK_LAST  = ACW'(ACK_TIMEOUT - 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(POLL_GAP - 1);
    localparam logic [ADDR_WIDTH-1:0] A_ARG  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_CMD  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_RESP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(25);

    typedef enum logic [1:0] {S_IDLE, S_ACK_LOW, S_REQ, S_GAP} state_t;
    typedef enum logic [2:0] {ST_ARG, ST_CMD, ST_POLL, ST_RESP, ST_CLR} step_t;

    state_t                r_state, w_state;
    step_t                 r_step, w_step;
    logic [ACW-1:0]        r_ack_cnt, w_ack_cnt;
    logic [PCW-1:0]        r_poll_cnt, w_poll_cnt;
    logic [GCW-1:0]        r_gap_cnt, w_gap_cnt;
    logic [1:0]            r_idx, w_idx;
    logic [31:0]           r_arg, w_arg;
    logic [15:0]           r_cmd, w_cmd, r_xfer, w_xfer;
    logic                  r_long, w_long;
    logic                  r_busy, w_busy, r_done, w_done;
    logic [1:0]            r_err, w_err;
    logic [127:0]          r_resp, w_resp;
    logic                  r_req, w_req, r_rw, w_rw;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
    logic                  w_fin;

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign response  = r_resp;
    assign reg_req   = r_req;
    assign reg_rw    = r_rw;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_step     <= ST_ARG;
            r_ack_cnt  <= '0;
            r_poll_cnt <= '0;
            r_gap_cnt  <= '0;
            r_idx      <= '0;
            r_arg      <= '0;
            r_cmd      <= '0;
            r_xfer     <= '0;
            r_long     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= '0;
            r_resp     <= '0;
            r_req      <= 1'b0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state;
            r_step     <= w_step;
            r_ack_cnt  <= w_ack_cnt;
            r_poll_cnt <= w_poll_cnt;
            r_gap_cnt  <= w_gap_cnt;
            r_idx      <= w_idx;
            r_arg      <= w_arg;
            r_cmd      <= w_cmd;
            r_xfer     <= w_xfer;
            r_long     <= w_long;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_resp     <= w_resp;
            r_req      <= w_req;
            r_rw       <= w_rw;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_step     = r_step;
        w_ack_cnt  = r_ack_cnt;
        w_poll_cnt = r_poll_cnt;
        w_gap_cnt  = r_gap_cnt;
        w_idx      = r_idx;
        w_arg      = r_arg;
        w_cmd      = r_cmd;
        w_xfer     = r_xfer;
        w_long     = r_long;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_err      = r_err;
        w_resp     = r_resp;
        w_req      = r_req;
        w_rw       = r_rw;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_fin      = 1'b0;
        case (r_state)
            S_IDLE: if (start) begin
                w_arg      = cmd_arg;
                w_cmd      = cmd_word;
                w_xfer     = xfer_mode;
                w_long     = long_resp;
                w_busy     = 1'b1;
                w_err      = '0;
                w_resp     = '0;
                w_step     = ST_ARG;
                w_idx      = '0;
                w_poll_cnt = '0;
                w_state    = S_ACK_LOW;
            end
            // a new request only goes out once the previous ack has dropped
            S_ACK_LOW: if (!reg_ack) begin
                w_req     = 1'b1;
                w_rw      = (r_step == ST_POLL) || (r_step == ST_RESP);
                w_addr    = r_step == ST_ARG  ? A_ARG :
                            r_step == ST_CMD  ? A_CMD :
                            r_step == ST_RESP ? A_RESP + ADDR_WIDTH'(r_idx) : A_STAT;
                w_wdata   = r_step == ST_ARG ? DATA_WIDTH'(r_arg) :
                            r_step == ST_CMD ? DATA_WIDTH'({r_cmd, r_xfer}) : '0;
                w_ack_cnt = '0;
                w_state   = S_REQ;
            end
            S_REQ: if (reg_ack) begin
                w_req   = 1'b0;
                w_state = S_ACK_LOW;
                case (r_step)
                    ST_ARG:  w_step = ST_CMD;
                    ST_CMD:  w_step = ST_POLL;
                    ST_POLL: if (reg_rdata[0]) begin
                        w_step = reg_rdata[1] ? ST_CLR : ST_RESP;
                        w_err  = reg_rdata[1] ? 2'd2 : r_err;
                    end else if (r_poll_cnt == POLL_LAST) begin
                        w_err = 2'd3;
                        w_fin = 1'b1;
                    end else begin
                        w_poll_cnt = r_poll_cnt + 1'b1;
                        w_gap_cnt  = '0;
                        w_state    = S_GAP;
                    end
                    ST_RESP: begin
                        w_resp[{r_idx, 5'd0} +: 32] = reg_rdata[31:0];
                        w_idx  = r_idx + 1'b1;
                        w_step = (!r_long || r_idx == 2'd3) ? ST_CLR : ST_RESP;
                    end
                    default: w_fin = 1'b1;
                endcase
            end else if (r_ack_cnt == ACK_LAST) begin
                w_req = 1'b0;
                w_err = 2'd1;
                w_fin = 1'b1;
            end else begin
                w_ack_cnt = r_ack_cnt + 1'b1;
            end
            S_GAP: begin
                w_gap_cnt = r_gap_cnt + 1'b1;
                w_state   = r_gap_cnt == GAP_LAST ? S_ACK_LOW : S_GAP;
            end
            default: w_state = S_IDLE;
        endcase
        if (w_fin) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
        end
    end
endmodule

// File: tb/tb_cmd_issue_master.sv
// tb_cmd_issue_master: directed scenarios against a register-bank model that
// logs every acknowledged access and serves a scripted status sequence.
module tb_cmd_issue_master;
    logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [31:0]  cmd_arg = '0;
    logic [15:0]  cmd_word = '0, xfer_mode = '0;
    logic         long_resp = 1'b0;
    logic         busy, done;
    logic [1:0]   err;
    logic [127:0] response;
    logic         reg_req, reg_rw;
    logic [4:0]   reg_addr;
    logic [31:0]  reg_wdata, reg_rdata;
    logic         reg_ack;

    always #5 clk = ~clk;

    cmd_issue_master #(.POLL_MAX(3)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_arg(cmd_arg), .cmd_word(cmd_word),
        .xfer_mode(xfer_mode), .long_resp(long_resp), .busy(busy), .done(done), .err(err),
        .response(response), .reg_req(reg_req), .reg_rw(reg_rw), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
    );

    int tests = 0, fails = 0;
    int cyc = 0;
    logic [31:0] mem [0:31];
    logic [31:0] stat_seq [0:7];
    int stat_len = 1, stat_start = 0, poll_n = 0, extra = 0, hold = 0;
    logic noack_en = 1'b0;
    logic ack_q = 1'b0;
    logic [31:0] rdata_q = '0;
    logic        log_rw   [0:255];
    logic [4:0]  log_addr [0:255];
    logic [31:0] log_wd   [0:255];
    int          log_cyc  [0:255];
    int n_log = 0, done_cnt = 0, stale_viol = 0, req_len = 0, last_req_len = 0;
    logic prev_req = 1'b0;

    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;

    function automatic logic [31:0] stat_at(int k);
        return (k < stat_len) ? stat_seq[k] : stat_seq[stat_len-1];
    endfunction

    function automatic logic [37:0] ent(logic rw, logic [4:0] a, logic [31:0] wd);
        return {rw, a, wd};
    endfunction

    function automatic logic [37:0] logged(int i);
        return {log_rw[i], log_addr[i], log_rw[i] ? 32'h0 : log_wd[i]};
    endfunction

    // registered-ack bank: acks one cycle after req, optionally holds ack longer
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ack_q) begin
            if (hold < extra) hold <= hold + 1;
            else begin
                ack_q <= 1'b0;
                hold  <= 0;
            end
        end else if (reg_req && !(noack_en && reg_addr == 5'd3)) begin
            ack_q   <= 1'b1;
            rdata_q <= reg_addr == 5'd25 ? stat_at(poll_n - stat_start) : mem[reg_addr];
            if (reg_addr == 5'd25 && reg_rw) poll_n <= poll_n + 1;
            log_rw[n_log]   <= reg_rw;
            log_addr[n_log] <= reg_addr;
            log_wd[n_log]   <= reg_wdata;
            log_cyc[n_log]  <= cyc;
            n_log           <= n_log + 1;
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        prev_req <= reg_req;
        if (reg_req && !prev_req && reg_ack) stale_viol <= stale_viol + 1;
        if (reg_req) req_len <= req_len + 1;
        else if (req_len > 0) begin
            last_req_len <= req_len;
            req_len      <= 0;
        end
    end

    task automatic setup(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                         input int len, input int ex);
        stat_seq[0] = s0;
        stat_seq[1] = s1;
        stat_seq[2] = s2;
        stat_len    = len;
        stat_start  = poll_n;
        extra       = ex;
    endtask

    task automatic kick(input logic [31:0] a, input logic [15:0] c, input logic [15:0] x, input logic l);
        @(negedge clk);
        cmd_arg = a; cmd_word = c; xfer_mode = x; long_resp = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cmd_arg = 32'hDEAD_BEEF; cmd_word = 16'hFFFF; xfer_mode = 16'hFFFF; long_resp = ~l;
    endtask

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s done_wait: done not seen within 3000 cycles", name);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s done_pulse: done=%b busy=%b one cycle later, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        start = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, err, reg_req} !== 5'b0 || response !== 128'h0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%0d req=%b resp=%h, expected all 0",
                     busy, done, err, reg_req, response);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || reg_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_start: busy=%b req=%b after start held in reset, expected 0 0", busy, reg_req);
        end
    endtask

    task automatic test_short;
        int base, d0;
        logic [37:0] exp [$];
        base = n_log; d0 = done_cnt;
        setup(32'h0, 32'h0, 32'h1, 3, 0);
        mem[4] = 32'hCAFE_0001;
        exp = '{ent(0, 2, 32'h1234_5678), ent(0, 3, 32'h0D1A_0000), ent(1, 25, 0), ent(1, 25, 0),
                ent(1, 25, 0), ent(1, 4, 0), ent(0, 25, 0)};
        kick(32'h1234_5678, 16'h0D1A, 16'h0000, 1'b0);
        wait_done("short");
        tests++;
        if (err !== 2'd0) begin fails++; $display("FAIL short err: got %0d expected 0", err); end
        tests++;
        if (response !== 128'hCAFE_0001) begin
            fails++; $display("FAIL short resp: got %h expected %h", response, 128'hCAFE_0001);
        end
        tests++;
        if (n_log - base != exp.size()) begin
            fails++; $display("FAIL short count: got %0d accesses expected %0d", n_log - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (logged(base + i) !== exp[i]) begin
                fails++; $display("FAIL short access%0d: got %h expected %h", i, logged(base + i), exp[i]);
            end
        end
        for (int i = 2; i < 4; i++) begin
            tests++;
            if (log_cyc[base+i+1] - log_cyc[base+i] - 2 < 4) begin
                fails++; $display("FAIL short poll_gap%0d: got %0d idle cycles expected >=4",
                                  i, log_cyc[base+i+1] - log_cyc[base+i] - 2);
            end
        end
        tests++;
        if (done_cnt != d0 + 1) begin
            fails++; $display("FAIL short done_count: got %0d expected %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic test_long;
        int base;
        logic [37:0] exp [$];
        base = n_log;
        setup(32'h1, 32'h1, 32'h1, 1, 0);
        mem[4] = 32'd1; mem[5] = 32'd2; mem[6] = 32'd3; mem[7] = 32'd4;
        exp = '{ent(0, 2, 32'hA5A5_0000), ent(0, 3, 32'h0211_0013), ent(1, 25, 0), ent(1, 4, 0),
                ent(1, 5, 0), ent(1, 6, 0), ent(1, 7, 0), ent(0, 25, 0)};
        kick(32'hA5A5_0000, 16'h0211, 16'h0013, 1'b1);
        wait_done("long");
        tests++;
        if (err !== 2'd0) begin fails++; $display("FAIL long err: got %0d expected 0", err); end
        tests++;
        if (response !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
            fails++; $display("FAIL long resp: got %h expected %h", response, {32'd4, 32'd3, 32'd2, 32'd1});
        end
        tests++;
        if (n_log - base != exp.size()) begin
            fails++; $display("FAIL long count: got %0d accesses expected %0d", n_log - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (logged(base + i) !== exp[i]) begin
                fails++; $display("FAIL long access%0d: got %h expected %h", i, logged(base + i), exp[i]);
            end
        end
    endtask

    task automatic test_index_err;
        int base;
        logic [37:0] exp [$];
        base = n_log;
        setup(32'h3, 32'h3, 32'h3, 1, 0);
        exp = '{ent(0, 2, 32'h0000_0000), ent(0, 3, 32'h3F00_0011), ent(1, 25, 0), ent(0, 25, 0)};
        kick(32'h0000_0000, 16'h3F00, 16'h0011, 1'b1);
        wait_done("idx_err");
        tests++;
        if (err !== 2'd2) begin fails++; $display("FAIL idx_err err: got %0d expected 2", err); end
        tests++;
        if (response !== 128'h0) begin fails++; $display("FAIL idx_err resp: got %h expected 0", response); end
        tests++;
        if (n_log - base != exp.size()) begin
            fails++; $display("FAIL idx_err count: got %0d accesses expected %0d", n_log - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (logged(base + i) !== exp[i]) begin
                fails++; $display("FAIL idx_err access%0d: got %h expected %h", i, logged(base + i), exp[i]);
            end
        end
    endtask

    task automatic test_ack_timeout;
        int base;
        base = n_log;
        setup(32'h1, 32'h1, 32'h1, 1, 0);
        noack_en = 1'b1;
        kick(32'h1111_2222, 16'h0100, 16'h0000, 1'b0);
        wait_done("ack_to");
        noack_en = 1'b0;
        tests++;
        if (err !== 2'd1) begin fails++; $display("FAIL ack_to err: got %0d expected 1", err); end
        tests++;
        if (last_req_len != 16) begin
            fails++; $display("FAIL ack_to req_len: req held %0d cycles expected 16", last_req_len);
        end
        tests++;
        if (n_log - base != 1 || logged(base) !== ent(0, 2, 32'h1111_2222)) begin
            fails++; $display("FAIL ack_to accesses: got %0d first %h expected 1 %h",
                              n_log - base, logged(base), ent(0, 2, 32'h1111_2222));
        end
        tests++;
        if (reg_req !== 1'b0) begin fails++; $display("FAIL ack_to req: got %b expected 0", reg_req); end
    endtask

    task automatic test_poll_timeout;
        int base;
        logic [37:0] exp [$];
        base = n_log;
        setup(32'h0, 32'h0, 32'h0, 1, 0);
        exp = '{ent(0, 2, 32'h0BAD_F00D), ent(0, 3, 32'h0800_0000), ent(1, 25, 0), ent(1, 25, 0), ent(1, 25, 0)};
        kick(32'h0BAD_F00D, 16'h0800, 16'h0000, 1'b0);
        wait_done("poll_to");
        tests++;
        if (err !== 2'd3) begin fails++; $display("FAIL poll_to err: got %0d expected 3", err); end
        tests++;
        if (n_log - base != exp.size()) begin
            fails++; $display("FAIL poll_to count: got %0d accesses expected %0d", n_log - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (logged(base + i) !== exp[i]) begin
                fails++; $display("FAIL poll_to access%0d: got %h expected %h", i, logged(base + i), exp[i]);
            end
        end
    endtask

    task automatic test_stale_ack;
        int base, sv0;
        logic [37:0] exp [$];
        base = n_log; sv0 = stale_viol;
        setup(32'h1, 32'h1, 32'h1, 1, 2);
        mem[4] = 32'h5A5A_0004;
        exp = '{ent(0, 2, 32'h7777_0000), ent(0, 3, 32'h0C00_0001), ent(1, 25, 0), ent(1, 4, 0), ent(0, 25, 0)};
        kick(32'h7777_0000, 16'h0C00, 16'h0001, 1'b0);
        wait_done("stale");
        repeat (4) @(negedge clk);
        extra = 0;
        tests++;
        if (stale_viol != sv0) begin
            fails++; $display("FAIL stale issue_on_ack: got %0d requests under high ack expected 0", stale_viol - sv0);
        end
        tests++;
        if (err !== 2'd0 || response !== 128'h5A5A_0004) begin
            fails++; $display("FAIL stale result: got err=%0d resp=%h expected 0 %h", err, response, 128'h5A5A_0004);
        end
        tests++;
        if (n_log - base != exp.size()) begin
            fails++; $display("FAIL stale count: got %0d accesses expected %0d", n_log - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (logged(base + i) !== exp[i]) begin
                fails++; $display("FAIL stale access%0d: got %h expected %h", i, logged(base + i), exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        logic seen;
        d0 = done_cnt; seen = 1'b0;
        setup(32'h0, 32'h0, 32'h0, 1, 0);
        kick(32'h4444_0000, 16'h0D00, 16'h0000, 1'b0);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (reg_req === 1'b1 && reg_addr === 5'd25) seen = 1'b1;
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL rst_mid poll_wait: no status read within 200 cycles"); end
        reset = 1'b1;
        #1;
        tests++;
        if (reg_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid immediate: req=%b busy=%b expected 0 0", reg_req, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        tests++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid no_done: got %0d done pulses busy=%b expected 0 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_start_busy;
        int base, d0, n_end;
        logic [37:0] exp [$];
        base = n_log; d0 = done_cnt;
        setup(32'h0, 32'h1, 32'h1, 2, 0);
        mem[4] = 32'h0000_BEEF;
        exp = '{ent(0, 2, 32'hABCD_0001), ent(0, 3, 32'h0500_0000), ent(1, 25, 0), ent(1, 25, 0),
                ent(1, 4, 0), ent(0, 25, 0)};
        kick(32'hABCD_0001, 16'h0500, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        cmd_arg = 32'h9999_9999; long_resp = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        n_end = n_log;
        repeat (20) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done_cnt != d0 + 1 || n_log != n_end) begin
            fails++; $display("FAIL busy_start ignored: busy=%b dones=%0d extra_accesses=%0d expected 0 1 0",
                              busy, done_cnt - d0, n_log - n_end);
        end
        tests++;
        if (response !== 128'h0000_BEEF) begin
            fails++; $display("FAIL busy_start resp: got %h expected %h", response, 128'h0000_BEEF);
        end
        tests++;
        if (n_end - base != exp.size()) begin
            fails++; $display("FAIL busy_start count: got %0d accesses expected %0d", n_end - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            tests++;
            if (logged(base + i) !== exp[i]) begin
                fails++; $display("FAIL busy_start access%0d: got %h expected %h", i, logged(base + i), exp[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        for (int i = 0; i < 8; i++) stat_seq[i] = 32'h0;
        test_reset;
        test_short;
        test_long;
        test_index_err;
        test_ack_timeout;
        test_poll_timeout;
        test_stale_ack;
        test_reset_mid;
        test_start_busy;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
